pe_col_drain: RTL

Output drain stage for one column of the PE array. Sits directly below the bottom PE of a column, captures the column's ACC_BW accumulator outputs as they emerge, rescales each to MUL_BW fixed point with saturation, and buffers them in a small FIFO. The FIFO feeds a valid/ready stream toward the result writeback. Frame bookkeeping signals completion once a programmed number of results has been captured and fully drained.

---
 rtl/pe_col_drain_if.sv | 30 +++
 rtl/pe_col_drain.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pe_col_drain_if.sv
// Capture/stream bundle for the column drain: accumulator capture input plus the
// valid/ready result stream toward writeback.
interface pe_col_drain_if #(
    parameter int unsigned ACC_BW = 32,
    parameter int unsigned MUL_BW = 16
);
    logic [ACC_BW-1:0] o_i;
    logic              o_vld;
    logic [MUL_BW-1:0] dout;
    logic              dout_vld;
    logic              dout_rdy;

    // Environment side: drives the accumulator feed and the consumer ready.
    modport master (
        output o_i,
        output o_vld,
        output dout_rdy,
        input  dout,
        input  dout_vld
    );

    // Drain stage side.
    modport slave (
        input  o_i,
        input  o_vld,
        input  dout_rdy,
        output dout,
        output dout_vld
    );
endinterface

// File: rtl/pe_col_drain.sv
// Column drain: captures accumulator results, rescales with saturation, buffers them in a
// show-ahead FIFO and reports frame completion once the programmed count has drained.
module pe_col_drain #(
    parameter int unsigned FRA_BW = 8,
    parameter int unsigned MUL_BW = 16,
    parameter int unsigned ACC_BW = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LEN_BW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_BW-1:0] cfg_len,
    pe_col_drain_if.slave     bus,
    output logic              busy,
    output logic              done,
    output logic              sat_flag,
    output logic              ovf_flag
);

    localparam int unsigned IDX_BW = $clog2(DEPTH);
    localparam int unsigned PTR_BW = IDX_BW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StCapt,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_BW-1:0] len_q, len_d;
    logic [LEN_BW-1:0] cnt_q, cnt_d;
    logic [LEN_BW-1:0] cnt_inc;
    logic              sat_q, sat_d;
    logic              ovf_q, ovf_d;

    logic [MUL_BW-1:0] mem_q [DEPTH];
    logic [PTR_BW-1:0] wr_q, rd_q;
    logic [PTR_BW-1:0] fill;
    logic              full, empty;
    logic              capt, push, pop;

    // ------------------------------------------------------------------
    // Rescale: drop FRA_BW fractional bits, saturate into MUL_BW signed.
    // ------------------------------------------------------------------
    logic signed [ACC_BW-1:0]   shifted;
    logic [ACC_BW-MUL_BW:0]     hi_bits;
    logic                       in_range;
    logic                       sat;
    logic [MUL_BW-1:0]          scaled;

    assign shifted  = $signed(bus.o_i) >>> FRA_BW;
    // Value fits when every bit above the MUL_BW sign bit matches it.
    assign hi_bits  = shifted[ACC_BW-1:MUL_BW-1];
    assign in_range = (&hi_bits) | ~(|hi_bits);
    assign sat      = ~in_range;

    always_comb begin
        scaled = shifted[MUL_BW-1:0];
        if (!in_range) begin
            if (shifted[ACC_BW-1]) begin
                scaled = {1'b1, {(MUL_BW-1){1'b0}}};
            end else begin
                scaled = {1'b0, {(MUL_BW-1){1'b1}}};
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit so full and empty differ.
    // ------------------------------------------------------------------
    assign fill  = wr_q - rd_q;
    assign empty = (fill == '0);
    assign full  = (fill == PTR_BW'(DEPTH));

    assign pop  = bus.dout_vld & bus.dout_rdy;
    assign capt = (state_q == StCapt) & bus.o_vld;
    // When full, a same-cycle pop frees the head slot that the push reuses.
    assign push = capt & (~full | pop);

    assign bus.dout_vld = ~empty;
    assign bus.dout     = empty ? '0 : mem_q[rd_q[IDX_BW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_q[IDX_BW-1:0]] <= scaled;
            end
            wr_q <= wr_q + {{(PTR_BW-1){1'b0}}, push};
            rd_q <= rd_q + {{(PTR_BW-1){1'b0}}, pop};
        end
    end

    // ------------------------------------------------------------------
    // Frame control
    // ------------------------------------------------------------------
    assign cnt_inc = cnt_q + LEN_BW'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q | (capt & sat);
        ovf_d   = ovf_q | (capt & ~push);
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = (cfg_len == '0) ? StDrain : StCapt;
                end
            end
            StCapt: begin
                // Drops still count toward the frame length.
                if (bus.o_vld) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (empty) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign sat_flag = sat_q;
    assign ovf_flag = ovf_q;

endmodule
